// File: rtl/bin2gray_stream.sv
// -----------------------------------------------------------------------------
// bin2gray_stream
//
// Streaming binary-to-Gray encoder with a small FIFO-style output buffer.
// Each accepted word is stored with a flag that says whether its Gray code
// differs from the previously accepted word's Gray code in exactly one bit.
// With this flag, a stream of counter values can be checked for clean
// single-step Gray transitions.
//
// Parameters:
//   W      data width in bits (>= 2)
//   DEPTH  output buffer entries (power of two, >= 2)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   binary word on b is valid
//   in_ready   out  buffer not full; a word can be accepted this cycle
//   b          in   binary input word
//   out_valid  out  buffer not empty; g/adj hold the head word
//   out_ready  in   downstream takes the head word this cycle
//   g          out  Gray-coded head word (0 when empty)
//   adj        out  head word is a single-bit step from its predecessor
//   count      out  number of buffered words
// -----------------------------------------------------------------------------
module bin2gray_stream #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               g,
    output logic                       adj,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    // Reflected binary code: keep the MSB, XOR each lower bit with its upper
    // neighbour.
    function automatic logic [W-1:0] to_gray(input logic [W-1:0] x);
        logic [W-1:0] r;
        r[W-1] = x[W-1];
        for (int i = 0; i < W-1; i++) begin
            r[i] = x[i+1] ^ x[i];
        end
        return r;
    endfunction

    // True when exactly one bit is set.
    function automatic logic one_hot(input logic [W-1:0] x);
        return (x != '0) && ((x & (x - 1'b1)) == '0);
    endfunction

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   count_q, count_d;
    logic [W-1:0]  last_q, last_d;
    logic          first_q, first_d;

    // Buffer storage holds data only; occupancy is tracked by count_q, so
    // the entries themselves need no reset.
    logic [W-1:0]  gmem_q [DEPTH];
    logic          amem_q [DEPTH];

    logic          push;
    logic          pop;
    logic [W-1:0]  gray_in;
    logic          adj_calc;

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign gray_in  = to_gray(b);
    assign adj_calc = first_q ? 1'b0 : one_hot(gray_in ^ last_q);

    // Outputs are forced to 0 while empty so that stale entries never show.
    assign g   = out_valid ? gmem_q[rd_q] : '0;
    assign adj = out_valid ? amem_q[rd_q] : 1'b0;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        last_d  = last_q;
        first_d = first_q;
        if (push) begin
            wr_d    = wr_q + 1'b1;   // DEPTH is a power of two: natural wrap
            last_d  = gray_in;
            first_d = 1'b0;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            last_q  <= '0;
            first_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            last_q  <= last_d;
            first_q <= first_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            gmem_q[wr_q] <= gray_in;
            amem_q[wr_q] <= adj_calc;
        end
    end

endmodule

// File: tb/tb_bin2gray_stream.sv
module tb_bin2gray_stream;

    localparam int W     = 4;
    localparam int DEPTH = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] g;
    logic         adj;
    logic [1:0]   count;

    bin2gray_stream #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .g         (g),
        .adj       (adj),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rnd    = 1'b0;

    // Scoreboard: {gray, adj} per accepted word, plus the reference state
    // used to predict adj.
    logic [W:0]   sb_q[$];
    logic [W-1:0] m_last  = '0;
    bit           m_first = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic flush_model();
        sb_q.delete();
        m_last  = '0;
        m_first = 1'b1;
    endtask

    // Runs at the falling edge: judges the transfers the coming rising edge
    // will perform.
    task automatic monitor();
        logic [W:0]   e;
        logic [W-1:0] ge;
        logic         ae;
        if (!rst_n) begin
            flush_model();
            return;
        end
        check("count", 32'(count), 32'(sb_q.size()));
        check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(sb_q.size() != DEPTH));
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("pop_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("pop_g", 32'(g), 32'(e[W:1]));
                check("pop_adj", 32'(adj), 32'(e[0]));
            end
        end else if (!out_valid) begin
            check("empty_g", 32'(g), 32'd0);
            check("empty_adj", 32'(adj), 32'd0);
        end
        if (in_valid && in_ready) begin
            ge = b ^ (b >> 1);
            ae = m_first ? 1'b0 : ($countones(ge ^ m_last) == 1);
            sb_q.push_back({ge, ae});
            m_last  = ge;
            m_first = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // Offers v until it is accepted; returns #1 after the accepting edge.
    task automatic push(input logic [W-1:0] v);
        bit acc = 1'b0;
        in_valid = 1'b1;
        b        = v;
        for (int k = 0; k < 200; k++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            acc = in_ready;
            tick();
            if (acc) break;
        end
        if (!acc) check("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        b         = '0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_g", 32'(g), 32'd0);
        check("rst_adj", 32'(adj), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Counting 0..3 with an always-ready sink.
        out_ready = 1'b1;
        push(4'd0);
        check("s0_valid", 32'(out_valid), 32'd1);
        check("s0_g", 32'(g), 32'b0000);
        check("s0_adj", 32'(adj), 32'd0);
        push(4'd1);
        check("s1_g", 32'(g), 32'b0001);
        check("s1_adj", 32'(adj), 32'd1);
        push(4'd2);
        check("s2_g", 32'(g), 32'b0011);
        check("s2_adj", 32'(adj), 32'd1);
        push(4'd3);
        check("s3_g", 32'(g), 32'b0010);
        check("s3_adj", 32'(adj), 32'd1);
        tick();
        check("s3_drained", 32'(out_valid), 32'd0);

        // Fill with a stalled sink; head must stay stable.
        out_ready = 1'b0;
        push(4'd5);
        push(4'd6);
        check("full_count", 32'(count), 32'd2);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_g", 32'(g), 32'b0111);
        check("full_adj", 32'(adj), 32'd0);
        repeat (3) tick();
        check("hold_g", 32'(g), 32'b0111);
        check("hold_adj", 32'(adj), 32'd0);
        out_ready = 1'b1;
        tick();
        check("pop1_g", 32'(g), 32'b0101);
        check("pop1_adj", 32'(adj), 32'd1);
        check("pop1_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("pop2_empty", 32'(out_valid), 32'd0);

        // Adjacency across non-consecutive values.
        push(4'd4);
        check("b4_g", 32'(g), 32'b0110);
        check("b4_adj", 32'(adj), 32'd0);
        push(4'd7);
        check("b7_g", 32'(g), 32'b0100);
        check("b7_adj", 32'(adj), 32'd1);
        push(4'd9);
        check("b9_g", 32'(g), 32'b1101);
        check("b9_adj", 32'(adj), 32'd0);
        tick();

        // Full buffer with input and output both active: pop only.
        out_ready = 1'b0;
        push(4'd10);
        push(4'd11);
        check("nb_count", 32'(count), 32'd2);
        in_valid  = 1'b1;
        b         = 4'd12;
        out_ready = 1'b1;
        tick();
        check("nb_count_after", 32'(count), 32'd1);
        check("nb_in_ready", 32'(in_ready), 32'd1);
        check("nb_head", 32'(g), 32'b1110);
        tick();
        in_valid = 1'b0;
        check("nb_accept_count", 32'(count), 32'd1);
        check("nb_accept_g", 32'(g), 32'b1010);
        tick();
        check("nb_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a cycle with two words held.
        out_ready = 1'b0;
        push(4'd1);
        push(4'd2);
        check("pre_rst_count", 32'(count), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_g", 32'(g), 32'd0);
        check("arst_adj", 32'(adj), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        flush_model();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(4'd15);
        check("post_rst_g", 32'(g), 32'b1000);
        check("post_rst_adj", 32'(adj), 32'd0);
        check("post_rst_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();

        // Long counting run under random back-pressure; many pointer wraps.
        rnd = 1'b1;
        for (int r = 0; r < 9; r++) begin
            for (int v = 0; v < 16; v++) begin
                push(4'(v));
            end
        end
        rnd       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (!out_valid) break;
            tick();
        end
        check("final_empty", 32'(out_valid), 32'd0);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
